cpu_datapath: RTL and testbench



---
 rtl/cpu_datapath.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_datapath.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Phase-1 bus-based CPU datapath: register file, priority bus encoder/mux, ADD/AND/IncPC ALU into 64-bit Z.
// Define DATAPATH_DEBUG_PORTS_EN to expose MAR and IR contents on MARval/IRval.
module cpu_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             R0in,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             R8in,
    input  logic             R9in,
    input  logic             R10in,
    input  logic             R11in,
    input  logic             R12in,
    input  logic             R13in,
    input  logic             R14in,
    input  logic             R15in,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             INPORTin,
    input  logic             Zin,
    input  logic             Yin,
    input  logic             MARin,
    input  logic             IRin,
    input  logic             AND,
    input  logic             R0out,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             R4out,
    input  logic             R5out,
    input  logic             R6out,
    input  logic             R7out,
    input  logic             R8out,
    input  logic             R9out,
    input  logic             R10out,
    input  logic             R11out,
    input  logic             R12out,
    input  logic             R13out,
    input  logic             R14out,
    input  logic             R15out,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             ZHIout,
    input  logic             ZLOout,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             INPORTout,
    input  logic             Zout,
    input  logic             Yout,
    input  logic             Read,
    input  logic             IncPC,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] busMuxOut,
    output logic [4:0]       encoderOut,
    output logic [WIDTH-1:0] BusMuxInR0,
    output logic [WIDTH-1:0] BusMuxInR1,
    output logic [WIDTH-1:0] BusMuxInR2,
    output logic [WIDTH-1:0] BusMuxInR3,
    output logic [WIDTH-1:0] BusMuxInR4,
    output logic [WIDTH-1:0] BusMuxInR5,
    output logic [WIDTH-1:0] BusMuxInR6,
    output logic [WIDTH-1:0] BusMuxInR7,
    output logic [WIDTH-1:0] BusMuxInR8,
    output logic [WIDTH-1:0] BusMuxInR9,
    output logic [WIDTH-1:0] BusMuxInR10,
    output logic [WIDTH-1:0] BusMuxInR11,
    output logic [WIDTH-1:0] BusMuxInR12,
    output logic [WIDTH-1:0] BusMuxInR13,
    output logic [WIDTH-1:0] BusMuxInR14,
    output logic [WIDTH-1:0] BusMuxInR15,
    output logic [WIDTH-1:0] BusMuxInHI,
    output logic [WIDTH-1:0] BusMuxInLO,
    output logic [WIDTH-1:0] BusMuxInZhi,
    output logic [WIDTH-1:0] BusMuxInZlo,
    output logic [WIDTH-1:0] BusMuxInPC,
    output logic [WIDTH-1:0] BusMuxInMDR,
    output logic [WIDTH-1:0] BusMuxInInport,
    output logic [WIDTH-1:0] BusMuxInY,
`ifdef DATAPATH_DEBUG_PORTS_EN
    output logic [WIDTH-1:0] MARval,
    output logic [WIDTH-1:0] IRval,
`endif
    input  logic             Clock,
    input  logic             Reset
);

    logic [WIDTH-1:0]   gpr_q [16];
    logic [WIDTH-1:0]   hi_q, lo_q, pc_q, mdr_q, inport_q, y_q, mar_q, ir_q;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0]   mdr_d, alu_lo;
    logic [15:0]        r_in, r_out;
    logic [24:0]        sel_vec;
    logic [4:0]         enc;
    logic               found;
    logic [WIDTH-1:0]   bus;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    // Bit position == encoder code; Zout aliases ZLOout, code 23 has no source.
    assign sel_vec = {Yout, 1'b0, INPORTout, MDRout, PCout, ZLOout | Zout,
                      ZHIout, LOout, HIout, r_out};

    always_comb begin
        enc   = '1;
        found = 1'b0;
        for (int unsigned i = 0; i < 25; i++) begin
            if (sel_vec[i] && !found) begin
                enc   = 5'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        bus = '0;
        if (enc < 5'd16) begin
            bus = gpr_q[enc[3:0]];
        end else begin
            case (enc)
                5'd16:   bus = hi_q;
                5'd17:   bus = lo_q;
                5'd18:   bus = z_q[2*WIDTH-1:WIDTH];
                5'd19:   bus = z_q[WIDTH-1:0];
                5'd20:   bus = pc_q;
                5'd21:   bus = mdr_q;
                5'd22:   bus = inport_q;
                5'd24:   bus = y_q;
                default: bus = '0;
            endcase
        end
    end

    always_comb begin
        if (IncPC)
            alu_lo = bus + 1'b1;
        else if (AND)
            alu_lo = y_q & bus;
        else
            alu_lo = y_q + bus;
        z_d   = {{WIDTH{1'b0}}, alu_lo};
        mdr_d = Read ? Mdatain : bus;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < 16; i++) gpr_q[i] <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            pc_q     <= '0;
            mdr_q    <= '0;
            inport_q <= '0;
            y_q      <= '0;
            mar_q    <= '0;
            ir_q     <= '0;
            z_q      <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++)
                if (r_in[i]) gpr_q[i] <= bus;
            if (HIin)     hi_q     <= bus;
            if (LOin)     lo_q     <= bus;
            if (PCin)     pc_q     <= bus;
            if (MDRin)    mdr_q    <= mdr_d;
            if (INPORTin) inport_q <= bus;
            if (Yin)      y_q      <= bus;
            if (MARin)    mar_q    <= bus;
            if (IRin)     ir_q     <= bus;
            if (Zin)      z_q      <= z_d;
        end
    end

    assign busMuxOut      = bus;
    assign encoderOut     = enc;
    assign BusMuxInR0     = gpr_q[0];
    assign BusMuxInR1     = gpr_q[1];
    assign BusMuxInR2     = gpr_q[2];
    assign BusMuxInR3     = gpr_q[3];
    assign BusMuxInR4     = gpr_q[4];
    assign BusMuxInR5     = gpr_q[5];
    assign BusMuxInR6     = gpr_q[6];
    assign BusMuxInR7     = gpr_q[7];
    assign BusMuxInR8     = gpr_q[8];
    assign BusMuxInR9     = gpr_q[9];
    assign BusMuxInR10    = gpr_q[10];
    assign BusMuxInR11    = gpr_q[11];
    assign BusMuxInR12    = gpr_q[12];
    assign BusMuxInR13    = gpr_q[13];
    assign BusMuxInR14    = gpr_q[14];
    assign BusMuxInR15    = gpr_q[15];
    assign BusMuxInHI     = hi_q;
    assign BusMuxInLO     = lo_q;
    assign BusMuxInZhi    = z_q[2*WIDTH-1:WIDTH];
    assign BusMuxInZlo    = z_q[WIDTH-1:0];
    assign BusMuxInPC     = pc_q;
    assign BusMuxInMDR    = mdr_q;
    assign BusMuxInInport = inport_q;
    assign BusMuxInY      = y_q;

`ifdef DATAPATH_DEBUG_PORTS_EN
    assign MARval = mar_q;
    assign IRval  = ir_q;
`else
    logic unused_regs;
    assign unused_regs = ^{mar_q, ir_q};
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed register-transfer sequences plus random strobes against a bus-code-indexed model.
// Define DATAPATH_DEBUG_PORTS_EN to also check MARval/IRval.
module tb_cpu_datapath;

    logic        Clock = 1'b0;
    logic        rst;
    logic [15:0] rin, rout;
    logic        hiin, loin, pcin, mdrin, inportin, zin, yin, marin, irin, and_op;
    logic        hiout, loout, zhiout, zloout, pcout, mdrout, inportout, zout, yout;
    logic        read, incpc;
    logic [31:0] mdatain;

    logic [31:0] busMuxOut;
    logic [4:0]  encoderOut;
    logic [31:0] obs_r [16];
    logic [31:0] obs_hi, obs_lo, obs_zhi, obs_zlo, obs_pc, obs_mdr, obs_inport, obs_y;
`ifdef DATAPATH_DEBUG_PORTS_EN
    logic [31:0] obs_mar, obs_ir;
    logic [31:0] m_mar, m_ir;
`endif

    // Model: src[code] holds whatever the bus would carry for that encoder code.
    logic [31:0] src [32];
    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    cpu_datapath #(.WIDTH(32)) dut (
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(hiin), .LOin(loin), .PCin(pcin), .MDRin(mdrin), .INPORTin(inportin),
        .Zin(zin), .Yin(yin), .MARin(marin), .IRin(irin), .AND(and_op),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(hiout), .LOout(loout), .ZHIout(zhiout), .ZLOout(zloout), .PCout(pcout),
        .MDRout(mdrout), .INPORTout(inportout), .Zout(zout), .Yout(yout),
        .Read(read), .IncPC(incpc), .Mdatain(mdatain),
        .busMuxOut(busMuxOut), .encoderOut(encoderOut),
        .BusMuxInR0(obs_r[0]), .BusMuxInR1(obs_r[1]), .BusMuxInR2(obs_r[2]),
        .BusMuxInR3(obs_r[3]), .BusMuxInR4(obs_r[4]), .BusMuxInR5(obs_r[5]),
        .BusMuxInR6(obs_r[6]), .BusMuxInR7(obs_r[7]), .BusMuxInR8(obs_r[8]),
        .BusMuxInR9(obs_r[9]), .BusMuxInR10(obs_r[10]), .BusMuxInR11(obs_r[11]),
        .BusMuxInR12(obs_r[12]), .BusMuxInR13(obs_r[13]), .BusMuxInR14(obs_r[14]),
        .BusMuxInR15(obs_r[15]),
        .BusMuxInHI(obs_hi), .BusMuxInLO(obs_lo), .BusMuxInZhi(obs_zhi),
        .BusMuxInZlo(obs_zlo), .BusMuxInPC(obs_pc), .BusMuxInMDR(obs_mdr),
        .BusMuxInInport(obs_inport), .BusMuxInY(obs_y),
`ifdef DATAPATH_DEBUG_PORTS_EN
        .MARval(obs_mar), .IRval(obs_ir),
`endif
        .Clock(Clock), .Reset(rst)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_strobes();
        rin = '0; rout = '0;
        {hiin, loin, pcin, mdrin, inportin, zin, yin, marin, irin, and_op} = '0;
        {hiout, loout, zhiout, zloout, pcout, mdrout, inportout, zout, yout} = '0;
        read = 1'b0; incpc = 1'b0; rst = 1'b0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) check_eq($sformatf("R%0d", i), obs_r[i], src[i]);
        check_eq("HI", obs_hi, src[16]);
        check_eq("LO", obs_lo, src[17]);
        check_eq("Zhi", obs_zhi, src[18]);
        check_eq("Zlo", obs_zlo, src[19]);
        check_eq("PC", obs_pc, src[20]);
        check_eq("MDR", obs_mdr, src[21]);
        check_eq("INPORT", obs_inport, src[22]);
        check_eq("Y", obs_y, src[24]);
`ifdef DATAPATH_DEBUG_PORTS_EN
        check_eq("MAR", obs_mar, m_mar);
        check_eq("IR", obs_ir, m_ir);
`endif
    endtask

    // One clock: check bus/encoder before the edge, update model, check registers after.
    task automatic cycle();
        logic [24:0] outs;
        int          code;
        logic [31:0] bus, alu, mdr_n;
        outs = {yout, 1'b0, inportout, mdrout, pcout, zloout | zout, zhiout, loout, hiout, rout};
        code = 31;
        for (int i = 0; i < 25; i++) begin
            if (outs[i]) begin
                code = i;
                break;
            end
        end
        bus   = (code == 31) ? 32'h0 : src[code];
        alu   = incpc ? bus + 32'd1 : (and_op ? (src[24] & bus) : (src[24] + bus));
        mdr_n = read ? mdatain : bus;
        #2;
        check_eq("encoderOut", {59'd0, encoderOut}, code);
        check_eq("busMuxOut", busMuxOut, bus);
        @(posedge Clock);
        if (rst) begin
            for (int i = 0; i < 32; i++) src[i] = '0;
`ifdef DATAPATH_DEBUG_PORTS_EN
            m_mar = '0; m_ir = '0;
`endif
        end else begin
            for (int i = 0; i < 16; i++) if (rin[i]) src[i] = bus;
            if (hiin)     src[16] = bus;
            if (loin)     src[17] = bus;
            if (zin)      begin src[18] = 32'h0; src[19] = alu; end
            if (pcin)     src[20] = bus;
            if (mdrin)    src[21] = mdr_n;
            if (inportin) src[22] = bus;
            if (yin)      src[24] = bus;
`ifdef DATAPATH_DEBUG_PORTS_EN
            if (marin)    m_mar = bus;
            if (irin)     m_ir = bus;
`endif
        end
        #1;
        check_regs();
        clear_strobes();
    endtask

    task automatic load_gpr(input int idx, input logic [31:0] val);
        mdatain = val; read = 1'b1; mdrin = 1'b1;
        cycle();
        mdrout = 1'b1; rin[idx] = 1'b1;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) src[i] = '0;
`ifdef DATAPATH_DEBUG_PORTS_EN
        m_mar = '0; m_ir = '0;
`endif
        clear_strobes();
        mdatain = '0;
        rst = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        rst = 1'b0;

        // Idle after reset
        cycle();
        check_eq("idle_enc", {59'd0, encoderOut}, 64'd31);
        check_eq("idle_bus", busMuxOut, 64'd0);

        // Memory -> MDR -> R4
        mdatain = 32'h12; read = 1'b1; mdrin = 1'b1;
        cycle();
        check_eq("mdr_12", obs_mdr, 64'h12);
        mdrout = 1'b1; rin[4] = 1'b1;
        #2 check_eq("mdr_enc", {59'd0, encoderOut}, 64'd21);
        #0 cycle();
        check_eq("r4_12", obs_r[4], 64'h12);

        // PC increment through Z
        pcout = 1'b1; marin = 1'b1; incpc = 1'b1; zin = 1'b1;
        cycle();
        check_eq("zlo_inc", obs_zlo, 64'd1);
        zloout = 1'b1; pcin = 1'b1;
        #2 check_eq("zlo_enc", {59'd0, encoderOut}, 64'd19);
        #0 cycle();
        check_eq("pc_1", obs_pc, 64'd1);

        // Instruction fetch into IR
        mdatain = 32'h1891_8000; read = 1'b1; mdrin = 1'b1;
        cycle();
        mdrout = 1'b1; irin = 1'b1;
        cycle();
`ifdef DATAPATH_DEBUG_PORTS_EN
        check_eq("ir_fetch", obs_ir, 64'h1891_8000);
`endif

        // ADD then AND of R2, R3 into R0
        load_gpr(2, 32'h14);
        load_gpr(3, 32'h18);
        for (int op = 0; op < 2; op++) begin
            rout[2] = 1'b1; yin = 1'b1;
            cycle();
            rout[3] = 1'b1; zin = 1'b1; and_op = op[0];
            cycle();
            zloout = 1'b1; rin[0] = 1'b1;
            cycle();
            check_eq(op == 0 ? "add_r0" : "and_r0", obs_r[0], op == 0 ? 64'h2C : 64'h10);
            check_eq("zhi_zero", obs_zhi, 64'd0);
        end

        // Priority between two sources
        rout[2] = 1'b1; rout[5] = 1'b1; rin[7] = 1'b1;
        #2;
        check_eq("prio_enc", {59'd0, encoderOut}, 64'd2);
        check_eq("prio_bus", busMuxOut, 64'h14);
        #0 cycle();

        // Reset overrides a load
        zloout = 1'b1; rin[0] = 1'b1; rst = 1'b1;
        cycle();
        check_eq("rst_r0", obs_r[0], 64'd0);

        // Random strobes
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 16; i++) begin
                rout[i] = ($urandom_range(0, 19) == 0);
                rin[i]  = ($urandom_range(0, 7) == 0);
            end
            {hiout, loout, zhiout, zloout} = {($urandom_range(0, 12) == 0), ($urandom_range(0, 12) == 0),
                                              ($urandom_range(0, 12) == 0), ($urandom_range(0, 12) == 0)};
            {pcout, mdrout, inportout, zout, yout} = {($urandom_range(0, 12) == 0), ($urandom_range(0, 8) == 0),
                                                      ($urandom_range(0, 12) == 0), ($urandom_range(0, 12) == 0),
                                                      ($urandom_range(0, 10) == 0)};
            {hiin, loin, pcin, inportin} = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            {zin, yin, marin, irin} = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            mdrin   = ($urandom_range(0, 2) == 0);
            read    = $urandom_range(0, 1) == 1;
            and_op  = $urandom_range(0, 1) == 1;
            incpc   = ($urandom_range(0, 4) == 0);
            mdatain = (n % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            rst     = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
